pbuff_sobel_scan: RTL

//  Downstream consumer of the partial (row-slice) buffer. On each slice commit it scans columns
//  0..HWIDTH-1 by driving the buffer read address. From rows 0..2 of each returned column it

---
 rtl/pbuff_sobel_scan_if.sv | 41 ++++
 rtl/pbuff_sobel_scan.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/pbuff_sobel_scan_if.sv
// Bus between the Sobel column scanner, the partial buffer read port and the pixel write stage.
// master = scanner side, slave = buffer/consumer side.
interface pbuff_sobel_scan_if #(
  parameter int AWIDTH = 10,
  parameter int DWIDTH = 12,
  parameter int SLICE  = 3
);
  logic                      start;
  logic [AWIDTH-1:0]         raddr;
  logic [DWIDTH*SLICE-1:0]   rdata;
  logic                      busy;
  logic                      out_valid;
  logic [AWIDTH-1:0]         out_col;
  logic [DWIDTH-1:0]         out_pix;
  logic                      done;
  logic                      overrun;

  modport master (
    input  start,
    input  rdata,
    output raddr,
    output busy,
    output out_valid,
    output out_col,
    output out_pix,
    output done,
    output overrun
  );

  modport slave (
    output start,
    output rdata,
    input  raddr,
    input  busy,
    input  out_valid,
    input  out_col,
    input  out_pix,
    input  done,
    input  overrun
  );
endinterface

// File: rtl/pbuff_sobel_scan.sv
// Scans a committed partial-buffer slice column by column and streams a 3x3 Sobel edge magnitude
// of the centre row as RGB444 grey. Optional macro SOBEL_BORDER_REPLICATE_EN replicates edge columns.
module pbuff_sobel_scan #(
  parameter int HWIDTH = 640,
  parameter int AWIDTH = 10,
  parameter int DWIDTH = 12,
  parameter int SLICE  = 3
) (
  input  logic               clk,
  input  logic               rst,
  pbuff_sobel_scan_if.master bus
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SCAN  = 2'd1;
  localparam logic [1:0] ST_FLUSH = 2'd2;

  localparam logic [AWIDTH-1:0] LAST_COL = AWIDTH'(HWIDTH - 1);

  logic [1:0]        state;
  logic [AWIDTH-1:0] raddr_q;
  logic              overrun_q;

  // Pipeline: read issue -> rdata -> luma -> window centre -> output register.
  logic              rd_vld;
  logic [AWIDTH-1:0] rd_col;
  logic              y_vld;
  logic [AWIDTH-1:0] y_col;
  logic              c_vld;
  logic [AWIDTH-1:0] c_col;

  // Each window column packs three 6-bit luma values, row r at [6*r +: 6].
  logic [17:0]       lum_n;
  logic [17:0]       win_c;
  logic [17:0]       win_p;
  logic [17:0]       lum_rdata;

  logic              out_valid_q;
  logic [AWIDTH-1:0] out_col_q;
  logic [DWIDTH-1:0] out_pix_q;
  logic              done_q;

  function automatic logic [5:0] luma(input logic [11:0] p);
    return {2'b00, p[11:8]} + {1'b0, p[7:4], 1'b0} + {2'b00, p[3:0]};
  endfunction

  function automatic logic [7:0] wsum(input logic [5:0] a, input logic [5:0] b,
                                      input logic [5:0] c);
    return {2'b00, a} + {1'b0, b, 1'b0} + {2'b00, c};
  endfunction

  function automatic logic [7:0] abs9(input logic signed [8:0] v);
    logic [8:0] m;
    m = v[8] ? 9'(-v) : 9'(v);
    return m[7:0];
  endfunction

  always_comb begin
    lum_rdata = '0;
    for (int r = 0; r < 3; r++) begin
      lum_rdata[6*r +: 6] = luma(bus.rdata[DWIDTH*r +: 12]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      raddr_q   <= '0;
      overrun_q <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.start) begin
            state   <= ST_SCAN;
            raddr_q <= '0;
          end
        end
        ST_SCAN: begin
          if (raddr_q == LAST_COL) begin
            state <= ST_FLUSH;
          end else begin
            raddr_q <= raddr_q + 1'b1;
          end
        end
        ST_FLUSH: begin
          if (done_q) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
      if (bus.start && (state != ST_IDLE)) begin
        overrun_q <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_vld <= 1'b0;
      rd_col <= '0;
      y_vld  <= 1'b0;
      y_col  <= '0;
      c_vld  <= 1'b0;
      c_col  <= '0;
      lum_n  <= '0;
      win_c  <= '0;
      win_p  <= '0;
    end else begin
      rd_vld <= (state == ST_SCAN);
      rd_col <= raddr_q;
      y_vld  <= rd_vld;
      y_col  <= rd_col;
      c_vld  <= y_vld;
      c_col  <= y_col;
      lum_n  <= lum_rdata;
      win_c  <= lum_n;
      win_p  <= win_c;
    end
  end

  // Neighbour selection: at the borders the missing column never comes from the buffer.
  logic [17:0]       col_l;
  logic [17:0]       col_r;
  logic              zero_border;
  logic [7:0]        sum_l;
  logic [7:0]        sum_r;
  logic [7:0]        sum_top;
  logic [7:0]        sum_bot;
  logic signed [8:0] gx;
  logic signed [8:0] gy;
  logic [8:0]        mag;
  logic [3:0]        g;

  always_comb begin
    col_l       = win_p;
    col_r       = lum_n;
    zero_border = 1'b0;
    if (c_col == '0) begin
`ifdef SOBEL_BORDER_REPLICATE_EN
      col_l = win_c;
`else
      zero_border = 1'b1;
`endif
    end
    if (c_col == LAST_COL) begin
`ifdef SOBEL_BORDER_REPLICATE_EN
      col_r = win_c;
`else
      zero_border = 1'b1;
`endif
    end

    sum_l   = wsum(col_l[5:0], col_l[11:6], col_l[17:12]);
    sum_r   = wsum(col_r[5:0], col_r[11:6], col_r[17:12]);
    sum_top = wsum(col_l[5:0], win_c[5:0], col_r[5:0]);
    sum_bot = wsum(col_l[17:12], win_c[17:12], col_r[17:12]);
    gx      = $signed({1'b0, sum_r}) - $signed({1'b0, sum_l});
    gy      = $signed({1'b0, sum_bot}) - $signed({1'b0, sum_top});
    mag     = {1'b0, abs9(gx)} + {1'b0, abs9(gy)};
    g       = (mag[8:3] > 6'd15) ? 4'hF : mag[6:3];
    if (zero_border) begin
      g = 4'h0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_col_q   <= '0;
      out_pix_q   <= '0;
      done_q      <= 1'b0;
    end else begin
      out_valid_q <= c_vld;
      done_q      <= c_vld && (c_col == LAST_COL);
      if (c_vld) begin
        out_col_q <= c_col;
        out_pix_q <= {g, g, g};
      end
    end
  end

  assign bus.raddr     = raddr_q;
  assign bus.busy      = (state != ST_IDLE);
  assign bus.out_valid = out_valid_q;
  assign bus.out_col   = out_col_q;
  assign bus.out_pix   = out_pix_q;
  assign bus.done      = done_q;
  assign bus.overrun   = overrun_q;

endmodule
